// File: rtl/bus_switch.sv
// Single-master, NSLV-slave RISC5 bus switch: base/mask decode, registered IDLE/ACCESS/RESP FSM.
// Optional error log (err_irq/err_addr) is built only when BUS_SWITCH_ERRLOG_EN is defined.
module bus_switch #(
  parameter int unsigned          NSLV    = 4,
  parameter logic [NSLV*22-1:0]   BASE    = {NSLV{22'h0}},
  parameter logic [NSLV*22-1:0]   MASK    = {NSLV{22'h0}},
  parameter int unsigned          TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_stb,
  input  logic               m_we,
  input  logic [21:0]        m_addr,
  input  logic [31:0]        m_dout,
  output logic [31:0]        m_din,
  output logic               m_ack,
  output logic               m_err,
  output logic [NSLV-1:0]    s_stb,
  output logic               s_we,
  output logic [21:0]        s_addr,
  output logic [31:0]        s_data,
  input  logic [NSLV*32-1:0] s_din,
  input  logic [NSLV-1:0]    s_ack,
  input  logic               err_clr,
  output logic               err_irq,
  output logic [21:0]        err_addr
);

  localparam int unsigned SelW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutM1 = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSLV-1:0] s_stb_q, s_stb_d;
  logic            s_we_q, s_we_d;
  logic [21:0]     s_addr_q, s_addr_d;
  logic [31:0]     s_data_q, s_data_d;
  logic [31:0]     m_din_q, m_din_d;
  logic            m_ack_q, m_ack_d;
  logic            m_err_q, m_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic            hit;
  logic [SelW-1:0] hit_idx;
  logic            ack_sel;
  logic [31:0]     rd_sel;
  logic            err_set;

  // Walk from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((m_addr & MASK[i*22 +: 22]) == BASE[i*22 +: 22]) begin
        hit     = 1'b1;
        hit_idx = SelW'(i);
      end
    end
  end

  always_comb begin
    ack_sel = 1'b0;
    rd_sel  = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_q == SelW'(i)) begin
        ack_sel = s_ack[i];
        rd_sel  = s_din[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    s_stb_d  = s_stb_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    m_din_d  = m_din_q;
    m_ack_d  = 1'b0;
    m_err_d  = m_err_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    err_set  = 1'b0;
    case (state_q)
      StIdle: begin
        if (m_stb) begin
          s_we_d   = m_we;
          s_addr_d = m_addr;
          s_data_d = m_dout;
          if (hit) begin
            s_stb_d          = '0;
            s_stb_d[hit_idx] = 1'b1;
            sel_d            = hit_idx;
            cnt_d            = '0;
            state_d          = StAccess;
          end else begin
            m_err_d = 1'b1;
            m_din_d = '0;
            m_ack_d = 1'b1;
            err_set = 1'b1;
            state_d = StResp;
          end
        end
      end
      StAccess: begin
        if (ack_sel) begin
          m_din_d = s_we_q ? 32'h0 : rd_sel;
          m_err_d = 1'b0;
          s_stb_d = '0;
          m_ack_d = 1'b1;
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == TimeoutM1)) begin
          s_stb_d = '0;
          m_err_d = 1'b1;
          m_din_d = '0;
          m_ack_d = 1'b1;
          err_set = 1'b1;
          state_d = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      s_stb_q  <= '0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_data_q <= '0;
      m_din_q  <= '0;
      m_ack_q  <= 1'b0;
      m_err_q  <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_stb_q  <= s_stb_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      m_din_q  <= m_din_d;
      m_ack_q  <= m_ack_d;
      m_err_q  <= m_err_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
    end
  end

  assign s_stb  = s_stb_q;
  assign s_we   = s_we_q;
  assign s_addr = s_addr_q;
  assign s_data = s_data_q;
  assign m_din  = m_din_q;
  assign m_ack  = m_ack_q;
  assign m_err  = m_err_q;

`ifdef BUS_SWITCH_ERRLOG_EN
  logic        err_irq_q;
  logic [21:0] err_addr_q;

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
    end else if (err_set) begin
      err_irq_q  <= 1'b1;
      err_addr_q <= s_addr_d;
    end else if (err_clr) begin
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
    end
  end

  assign err_irq  = err_irq_q;
  assign err_addr = err_addr_q;
`else
  logic unused_errlog;
  assign unused_errlog = ^{err_clr, err_set};
  assign err_irq  = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_bus_switch.sv
// Directed bench for bus_switch: table of transactions plus reset-abort and error-log sequences.
module tb_bus_switch;

  localparam logic [43:0] TbBase = {22'h3FFFF0, 22'h000000};
  localparam logic [43:0] TbMask = {22'h3FFFFC, 22'h200000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_stb = 1'b0;
  logic        m_we = 1'b0;
  logic [21:0] m_addr = '0;
  logic [31:0] m_dout = '0;
  logic [31:0] m_din;
  logic        m_ack;
  logic        m_err;
  logic [1:0]  s_stb;
  logic        s_we;
  logic [21:0] s_addr;
  logic [31:0] s_data;
  logic [63:0] s_din = '0;
  logic [1:0]  s_ack = '0;
  logic        err_clr = 1'b0;
  logic        err_irq;
  logic [21:0] err_addr;

  bus_switch #(
    .NSLV    (2),
    .BASE    (TbBase),
    .MASK    (TbMask),
    .TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_din    (m_din),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .s_din    (s_din),
    .s_ack    (s_ack),
    .err_clr  (err_clr),
    .err_irq  (err_irq),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [31:0] wdata;
    int          slv;       // slave that answers
    int          ack_wait;  // wait cycles before ack, -1 = never
    logic        junk;      // unselected slave acks throughout
    logic [31:0] rdata;
    logic [1:0]  e_stb;
    int          e_stb_n;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_din;
  } vec_t;

  vec_t        vecs[6];
  int          n_vec = 0;
  int          n_err = 0;
  logic        log_irq = 1'b0;
  logic [21:0] log_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with the FSM back in IDLE.
  task automatic run_txn(input vec_t v);
    int         cyc;
    int         stb_n;
    logic       got;
    logic [1:0] stb_seen;
    logic [1:0] ack_mask;
    logic       f_we;
    logic [21:0] f_addr;
    logic [31:0] f_data;
    ack_mask = 2'b01 << v.slv;
    s_din = {32'hBAD0BAD0, 32'hBAD0BAD0};
    s_din[v.slv*32 +: 32] = v.rdata;
    m_we = v.we; m_addr = v.addr; m_dout = v.wdata; m_stb = 1'b1;
    @(posedge clk); #1;
    m_stb = 1'b0; m_dout = 32'hFFFF_FFFF;
    cyc = 0; stb_n = 0; got = 1'b0; stb_seen = '0;
    f_we = 1'b0; f_addr = '0; f_data = '0;
    while (!got && cyc < 40) begin
      s_ack = '0;
      if (m_ack) begin
        got = 1'b1;
        chk("latency", 64'(cyc + 1), 64'(v.e_lat));
        chk("m_err", m_err, v.e_err);
        chk("m_din", m_din, v.e_din);
        chk("s_stb in resp", s_stb, 2'b00);
`ifdef BUS_SWITCH_ERRLOG_EN
        if (v.e_err) begin log_irq = 1'b1; log_addr = v.addr; end
`endif
        chk("err_irq", err_irq, log_irq);
        chk("err_addr", err_addr, log_addr);
      end else if (s_stb != 2'b00) begin
        stb_n++;
        stb_seen |= s_stb;
        if (stb_n == 1) begin f_we = s_we; f_addr = s_addr; f_data = s_data; end
        if (v.ack_wait >= 0 && stb_n == v.ack_wait + 1) s_ack = ack_mask;
        if (v.junk) s_ack = s_ack | (~ack_mask);
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_ack = '0;
    chk("m_ack seen", got, 1'b1);
    chk("m_ack one cycle", m_ack, 1'b0);
    chk("m_din held", m_din, v.e_din);
    chk("s_stb value", stb_seen, v.e_stb);
    chk("s_stb cycles", 64'(stb_n), 64'(v.e_stb_n));
    if (v.e_stb_n > 0) begin
      chk("s_we", f_we, v.we);
      chk("s_addr", f_addr, v.addr);
      chk("s_data", f_data, v.wdata);
    end
  endtask

  initial begin
    logic seen;
    //        we    addr         wdata         slv wait junk rdata         stb  n  lat err din
    vecs[0] = '{1'b0, 22'h000100, 32'h0,        0,  0,  1'b0, 32'hDEADBEEF, 2'b01, 1, 2, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 22'h2F0000, 32'h0,        0, -1,  1'b0, 32'h11111111, 2'b00, 0, 1, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 22'h3FFFF1, 32'h12345678, 1,  3,  1'b0, 32'h55AA55AA, 2'b10, 4, 5, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 22'h3FFFF2, 32'h0,        1, -1,  1'b1, 32'h22222222, 2'b10, 8, 9, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 22'h3FFFF3, 32'h0,        1,  7,  1'b0, 32'hCAFEF00D, 2'b10, 8, 9, 1'b0, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 22'h1FFFFF, 32'h0,        0,  2,  1'b1, 32'h13579BDF, 2'b01, 3, 4, 1'b0, 32'h13579BDF};

    #2;
    chk("reset s_stb", s_stb, 2'b00);
    chk("reset m_ack", m_ack, 1'b0);
    chk("reset m_err", m_err, 1'b0);
    chk("reset m_din", m_din, 32'h0);
    chk("reset s_addr", s_addr, 22'h0);
    chk("reset err_irq", err_irq, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset in ACCESS: strobe clears at once and no ack ever follows.
    s_din = '0; m_we = 1'b0; m_addr = 22'h3FFFF0; m_stb = 1'b1;
    @(posedge clk); #1 m_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("stb before reset", s_stb, 2'b10);
    rst_n = 1'b0;
    #1 chk("stb async clear", s_stb, 2'b00);
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1 seen |= m_ack; end
    rst_n = 1'b1;
    log_irq = 1'b0; log_addr = '0;
    repeat (12) begin @(posedge clk); #1 seen |= m_ack; end
    chk("no ack after reset", seen, 1'b0);
    run_txn(vecs[0]);
    run_txn(vecs[1]);

    // Clear and a new error in the same cycle: the error wins.
    err_clr = 1'b1; m_we = 1'b0; m_addr = 22'h2E0000; m_stb = 1'b1;
    @(posedge clk); #1 m_stb = 1'b0; err_clr = 1'b0;
`ifdef BUS_SWITCH_ERRLOG_EN
    log_irq = 1'b1; log_addr = 22'h2E0000;
`endif
    chk("clr+err m_ack", m_ack, 1'b1);
    chk("clr+err m_err", m_err, 1'b1);
    chk("clr+err err_irq", err_irq, log_irq);
    chk("clr+err err_addr", err_addr, log_addr);
    @(posedge clk); #1;
    chk("log sticky", err_irq, log_irq);

    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    log_irq = 1'b0; log_addr = '0;
    chk("cleared err_irq", err_irq, log_irq);
    chk("cleared err_addr", err_addr, log_addr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
